// File: rtl/sync_counter_pkg.sv
// Shared width default and count type for the synchronous counter slice.
package sync_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : sync_counter_pkg

// File: rtl/sync_counter_tff.sv
// Single T flip-flop with asynchronous clear; one bit of the counter.
// Latency: toggles on the rising edge after t_i is sampled high.
// No backpressure: the flop updates on every edge.
module sync_counter_tff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic t_i,
  output logic q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= 1'b0;
    end else begin
      q_o <= q_o ^ t_i;
    end
  end

endmodule : sync_counter_tff

// File: rtl/sync_counter_4bit.sv
// Free-running synchronous binary up-counter built from T flip-flops.
// Latency: 1 cycle from reset release to q_o=1; q_o advances every edge.
// No backpressure: no enable or load, the count advances on every clock.
module sync_counter_4bit
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic [WIDTH-1:0] q_o
);

  // Each bit keeps its own toggle term so the carry is a serial AND chain:
  // bit i toggles once every lower bit is 1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic t;

    if (i == 0) begin : g_lsb
      assign t = 1'b1;
    end else begin : g_carry
      assign t = g_bit[i-1].t & q_o[i-1];
    end

    sync_counter_tff u_tff (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .t_i     (t),
      .q_o     (q_o[i])
    );
  end

`ifndef SYNTHESIS
  logic rst_seen;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_seen <= 1'b1;
    end
  end

  a_reset_zero : assert property (@(posedge clk_i) !rst_n_i |-> q_o == '0);

  a_increment : assert property (@(posedge clk_i) disable iff (rst_seen !== 1'b1)
    rst_n_i && $past(rst_n_i) |-> (q_o - $past(q_o)) == WIDTH'(1));

  a_no_x : assert property (@(posedge clk_i) (rst_seen === 1'b1) |-> !$isunknown(q_o));
`endif

endmodule : sync_counter_4bit

// File: tb/tb_sync_counter_4bit.sv
// Self-checking bench: scoreboard of per-edge expected counts plus vector table.
module tb_sync_counter_4bit;
  import sync_counter_pkg::*;

  logic       clk;
  logic       rst_n;
  count_t     q4;
  logic [5:0] q6;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m         = 0;

  count_t     exp_q4[$];
  logic [5:0] exp_q6[$];

  typedef struct {
    logic       rst_n;
    int         cycles;
    count_t     exp4;
    logic [5:0] exp6;
  } vec_t;

  vec_t vecs[10];

  sync_counter_4bit u_dut4 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .q_o     (q4)
  );

  sync_counter_4bit #(.WIDTH(6)) u_dut6 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .q_o     (q6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Drive reset level, take one edge, push the model's expectation, then compare.
  task automatic step(input logic rst);
    count_t     e4;
    logic [5:0] e6;
    rst_n = rst;
    @(posedge clk);
    if (!rst) m = 0;
    else      m = m + 1;
    exp_q4.push_back(count_t'(m % 16));
    exp_q6.push_back(6'(m % 64));
    #1;
    if (exp_q4.size() == 0 || exp_q6.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e4 = exp_q4.pop_front();
      e6 = exp_q6.pop_front();
      check("sb_cnt4", 32'(q4), 32'(e4));
      check("sb_cnt6", 32'(q6), 32'(e6));
    end
  endtask

  initial begin
    int hi3;
    int rise3;
    int tog0;
    logic prev3;
    logic prev0;
    int guard;

    vecs[0] = '{1'b0, 5,  4'd0,  6'd0};
    vecs[1] = '{1'b1, 1,  4'd1,  6'd1};
    vecs[2] = '{1'b1, 8,  4'd9,  6'd9};
    vecs[3] = '{1'b1, 6,  4'd15, 6'd15};
    vecs[4] = '{1'b1, 1,  4'd0,  6'd16};
    vecs[5] = '{1'b1, 3,  4'd3,  6'd19};
    vecs[6] = '{1'b0, 2,  4'd0,  6'd0};
    vecs[7] = '{1'b1, 1,  4'd1,  6'd1};
    vecs[8] = '{1'b1, 14, 4'd15, 6'd15};
    vecs[9] = '{1'b1, 2,  4'd1,  6'd17};

    // Power-up: reset asserted between edges must clear without a clock.
    rst_n = 1'b1;
    #10;
    rst_n = 1'b0;
    #1;
    check("por_clear4", 32'(q4), 32'd0);
    check("por_clear6", 32'(q6), 32'd0);
    #9;
    rst_n = 1'b1;
    #1;
    check("release_hold", 32'(q4), 32'd0);
    m = 0;

    // 40 free-running cycles; first edge (25ns) must give 1.
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      if (i == 0) check("first_edge", 32'(q4), 32'd1);
    end

    // Wrap: advance to 15, then one more edge must give 0.
    guard = 0;
    while (q4 != 4'd15 && guard < 16) begin
      step(1'b1);
      guard++;
    end
    check("reach15", 32'(q4), 32'd15);
    step(1'b1);
    check("wrap15_0", 32'(q4), 32'd0);

    // Vector table, each record starting from the state the previous one left.
    for (int v = 0; v < 10; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].rst_n);
      check($sformatf("vec%0d_q4", v), 32'(q4), 32'(vecs[v].exp4));
      check($sformatf("vec%0d_q6", v), 32'(q6), 32'(vecs[v].exp6));
    end

    // Asynchronous reset mid-count at 9, between edges.
    step(1'b0);
    for (int i = 0; i < 9; i++) step(1'b1);
    check("pre_async9", 32'(q4), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mid", 32'(q4), 32'd0);
    check("async_mid6", 32'(q6), 32'd0);
    step(1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1);
      check($sformatf("resume%0d", i), 32'(q4), 32'(i));
    end

    // Divider behaviour over 64 cycles from a fresh reset; q6 wraps 63 -> 0.
    step(1'b0);
    hi3 = 0;
    rise3 = 0;
    tog0 = 0;
    prev3 = q4[3];
    prev0 = q4[0];
    for (int i = 0; i < 64; i++) begin
      step(1'b1);
      if (q4[3]) hi3++;
      if (q4[3] && !prev3) rise3++;
      if (q4[0] != prev0) tog0++;
      prev3 = q4[3];
      prev0 = q4[0];
      if (i == 62) check("q6_at63", 32'(q6), 32'd63);
    end
    check("q3_high_cycles", 32'(hi3), 32'd32);
    check("q3_periods", 32'(rise3), 32'd4);
    check("q0_toggles", 32'(tog0), 32'd64);
    check("q6_wrap0", 32'(q6), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_sync_counter_4bit
